// File: rtl/btb_assoc_if.sv
// Fetch/execute-side bus of the branch target buffer: IF lookup, EX training, flush control.
interface btb_assoc_if;
  logic [31:0] pc_if;
  logic        hit_if;
  logic [31:0] target_if;
  logic        taken_if;
  logic        update_en;
  logic [31:0] pc_ex;
  logic [31:0] target_ex;
  logic        taken_ex;
  logic        flush_req;
  logic        flush_busy;

  modport master (
    output pc_if, update_en, pc_ex, target_ex, taken_ex, flush_req,
    input  hit_if, target_if, taken_if, flush_busy
  );

  modport slave (
    input  pc_if, update_en, pc_ex, target_ex, taken_ex, flush_req,
    output hit_if, target_if, taken_if, flush_busy
  );
endinterface

// File: rtl/btb_assoc.sv
// Set-associative BTB: combinational IF lookup, registered EX training with saturating
// direction counters, tree pseudo-LRU victim choice, and a one-set-per-cycle flush sweep.
module btb_way_match #(
  parameter int TAG_W = 23
) (
  input  logic             vld,
  input  logic [TAG_W-1:0] tag_q,
  input  logic [TAG_W-1:0] tag,
  output logic             hit
);
  assign hit = vld && (tag_q == tag);
endmodule

module btb_assoc #(
  parameter int ENTRIES = 256,
  parameter int WAYS    = 2,
  parameter int CNT_W   = 2
) (
  input logic        clk,
  input logic        rst,
  btb_assoc_if.slave bus
);
  localparam int SETS   = ENTRIES / WAYS;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = 32 - IDX_W - 2;
  localparam int LV     = $clog2(WAYS);
  localparam int WAY_W  = (WAYS > 1) ? LV : 1;
  localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {IDLE, SWEEP} state_t;

  logic [WAYS-1:0]              valid   [SETS];
  logic [PLRU_W-1:0]            plru    [SETS];
  logic [WAYS-1:0][TAG_W-1:0]   tag_mem [SETS];
  logic [WAYS-1:0][31:0]        tgt_mem [SETS];
  logic [WAYS-1:0][CNT_W-1:0]   cnt_mem [SETS];

  state_t           state;
  logic             busy;
  logic [IDX_W-1:0] sweep;

  // Tree walk: bit=1 sends the victim search to the upper-numbered half.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] b);
    int node;
    node = 0;
    for (int l = 0; l < LV; l++) node = 2 * node + 1 + int'(b[node]);
    return WAY_W'(node - (WAYS - 1));
  endfunction

  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] b,
                                                   input logic [WAY_W-1:0]  w);
    int node;
    logic d;
    logic [PLRU_W-1:0] r;
    r    = b;
    node = 0;
    for (int l = 0; l < LV; l++) begin
      d       = w[LV-1-l];
      r[node] = ~d;
      node    = 2 * node + 1 + int'(d);
    end
    return r;
  endfunction

  logic [IDX_W-1:0] idx_f, idx_e;
  logic [TAG_W-1:0] tag_f, tag_e;
  logic [WAYS-1:0]  hit_f, hit_e;
  logic             unused_pc;

  assign idx_f     = bus.pc_if[IDX_W+1:2];
  assign tag_f     = bus.pc_if[31:IDX_W+2];
  assign idx_e     = bus.pc_ex[IDX_W+1:2];
  assign tag_e     = bus.pc_ex[31:IDX_W+2];
  assign unused_pc = ^{bus.pc_if[1:0], bus.pc_ex[1:0]};

  generate
    for (genvar w = 0; w < WAYS; w++) begin : g_way
      btb_way_match #(.TAG_W(TAG_W)) u_match_f (
        .vld(valid[idx_f][w]), .tag_q(tag_mem[idx_f][w]), .tag(tag_f), .hit(hit_f[w])
      );
      btb_way_match #(.TAG_W(TAG_W)) u_match_e (
        .vld(valid[idx_e][w]), .tag_q(tag_mem[idx_e][w]), .tag(tag_e), .hit(hit_e[w])
      );
    end
  endgenerate

  // Lookup: at most one way matches, so an OR-mux of the gated ways is exact.
  logic [31:0] tgt_sel;
  logic        tk_sel;
  always_comb begin
    tgt_sel = '0;
    tk_sel  = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (hit_f[w]) begin
        tgt_sel = tgt_sel | tgt_mem[idx_f][w];
        tk_sel  = tk_sel | cnt_mem[idx_f][w][CNT_W-1];
      end
    end
  end

  assign bus.hit_if     = (|hit_f) && !busy;
  assign bus.target_if  = busy ? 32'h0 : tgt_sel;
  assign bus.taken_if   = tk_sel && !busy;
  assign bus.flush_busy = busy;

  logic [WAY_W-1:0] hit_way, vic_way, wr_way;
  logic             any_hit_e, upd_ok, do_hit, do_alloc, do_wr;
  logic [CNT_W-1:0] cnt_cur, cnt_nxt;

  always_comb begin
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) if (hit_e[w]) hit_way = WAY_W'(w);
    vic_way = plru_victim(plru[idx_e]);
    for (int w = WAYS - 1; w >= 0; w--) if (!valid[idx_e][w]) vic_way = WAY_W'(w);
  end

  // A flush request in IDLE takes priority; the coincident update is dropped.
  assign any_hit_e = |hit_e;
  assign upd_ok    = bus.update_en && (state == IDLE) && !bus.flush_req;
  assign do_hit    = upd_ok && any_hit_e;
  assign do_alloc  = upd_ok && !any_hit_e && bus.taken_ex;
  assign do_wr     = do_hit || do_alloc;
  assign wr_way    = any_hit_e ? hit_way : vic_way;
  assign cnt_cur   = cnt_mem[idx_e][wr_way];

  always_comb begin
    cnt_nxt = cnt_cur;
    if (do_alloc)          cnt_nxt = CNT_WEAK;
    else if (bus.taken_ex) cnt_nxt = (cnt_cur == CNT_MAX) ? cnt_cur : cnt_cur + 1'b1;
    else                   cnt_nxt = (cnt_cur == '0) ? cnt_cur : cnt_cur - 1'b1;
  end

  // Payload arrays carry no reset; they are meaningless while the valid bit is clear.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      tag_mem[idx_e][wr_way] <= tag_e;
      tgt_mem[idx_e][wr_way] <= bus.target_ex;
      cnt_mem[idx_e][wr_way] <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      sweep <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        plru[s]  <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.flush_req) begin
            state <= SWEEP;
            busy  <= 1'b1;
            sweep <= '0;
          end else if (do_wr) begin
            valid[idx_e][wr_way] <= 1'b1;
            plru[idx_e]          <= plru_touch(plru[idx_e], wr_way);
          end
        end
        SWEEP: begin
          valid[sweep] <= '0;
          plru[sweep]  <= '0;
          sweep        <= sweep + 1'b1;
          if (sweep == IDX_W'(SETS - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_btb_assoc.sv
// Directed bench for btb_assoc at default parameters (256 entries, 2 ways, 128 sets).
module tb_btb_assoc;
  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   n;

  btb_assoc_if bus ();

  btb_assoc #(.ENTRIES(256), .WAYS(2), .CNT_W(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge: apply pc_if and check the combinational result.
  task automatic look(input string tag, input logic [31:0] pc, input logic h,
                      input logic [31:0] tgt, input logic tk);
    bus.pc_if = pc;
    #1;
    chk({tag, ".hit"},    {31'b0, bus.hit_if},   {31'b0, h});
    chk({tag, ".target"}, bus.target_if,         tgt);
    chk({tag, ".taken"},  {31'b0, bus.taken_if}, {31'b0, tk});
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    @(negedge clk);
    bus.update_en = 1'b1;
    bus.pc_ex     = pc;
    bus.target_ex = tgt;
    bus.taken_ex  = tk;
    @(negedge clk);
    bus.update_en = 1'b0;
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    bus.flush_req = 1'b1;
    @(negedge clk);
    bus.flush_req = 1'b0;
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst           = 1'b1;
    bus.pc_if     = 32'h0;
    bus.update_en = 1'b0;
    bus.pc_ex     = 32'h0;
    bus.target_ex = 32'h0;
    bus.taken_ex  = 1'b0;
    bus.flush_req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("reset.busy", {31'b0, bus.flush_busy}, 32'h0);
    look("reset", 32'h100, 1'b0, 32'h0, 1'b0);

    // First allocation lands weakly taken.
    upd(32'h100, 32'h2000, 1'b1);
    look("alloc", 32'h100, 1'b1, 32'h2000, 1'b1);

    // Counter 2 -> 1 -> 0, target rewritten with the same value.
    upd(32'h100, 32'h2000, 1'b0);
    look("nt1", 32'h100, 1'b1, 32'h2000, 1'b0);
    upd(32'h100, 32'h2000, 1'b0);
    look("nt2", 32'h100, 1'b1, 32'h2000, 1'b0);
    // Floor at 0: one more not-taken then a single taken gives 1 (not taken).
    upd(32'h100, 32'h2000, 1'b0);
    upd(32'h100, 32'h2000, 1'b1);
    look("floor", 32'h100, 1'b1, 32'h2000, 1'b0);
    // 1 -> 2 -> 3, then a fourth taken must saturate at 3 so one not-taken leaves 2.
    upd(32'h100, 32'h2000, 1'b1);
    look("t2", 32'h100, 1'b1, 32'h2000, 1'b1);
    upd(32'h100, 32'h2000, 1'b1);
    upd(32'h100, 32'h2000, 1'b1);
    upd(32'h100, 32'h2000, 1'b0);
    look("sat", 32'h100, 1'b1, 32'h2000, 1'b1);
    upd(32'h100, 32'h2000, 1'b0);
    look("sat_nt2", 32'h100, 1'b1, 32'h2000, 1'b0);

    // Associativity within set 64.
    upd(32'h100, 32'hA00, 1'b1);
    upd(32'h300, 32'hB00, 1'b1);
    look("w0", 32'h100, 1'b1, 32'hA00, 1'b1);
    look("w1", 32'h300, 1'b1, 32'hB00, 1'b1);
    upd(32'h100, 32'hA00, 1'b1);
    upd(32'h500, 32'hC00, 1'b1);
    look("evict", 32'h300, 1'b0, 32'h0, 1'b0);
    look("keep100", 32'h100, 1'b1, 32'hA00, 1'b1);
    look("new500", 32'h500, 1'b1, 32'hC00, 1'b1);

    // Not-taken miss changes nothing.
    upd(32'h700, 32'hD00, 1'b0);
    look("ntmiss", 32'h700, 1'b0, 32'h0, 1'b0);
    look("ntmiss100", 32'h100, 1'b1, 32'hA00, 1'b1);
    look("ntmiss500", 32'h500, 1'b1, 32'hC00, 1'b1);

    // Same-cycle update and lookup: lookup sees the old contents.
    @(negedge clk);
    bus.update_en = 1'b1;
    bus.pc_ex     = 32'h904;
    bus.target_ex = 32'h4444;
    bus.taken_ex  = 1'b1;
    look("bypass", 32'h904, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    bus.update_en = 1'b0;
    look("after", 32'h904, 1'b1, 32'h4444, 1'b1);

    // Full flush; an update late in the sweep (after set 64 is cleared) must be dropped.
    pulse_flush();
    bus.pc_if = 32'h100;
    n = 0;
    while (bus.flush_busy && n < 200) begin
      #1;
      chk("sweep.hit", {31'b0, bus.hit_if}, 32'h0);
      bus.update_en = (n == 100);
      bus.pc_ex     = 32'hD00;
      bus.target_ex = 32'h5555;
      bus.taken_ex  = 1'b1;
      n++;
      @(negedge clk);
    end
    bus.update_en = 1'b0;
    chk("sweep.len", n, 128);
    look("fl100", 32'h100, 1'b0, 32'h0, 1'b0);
    look("fl500", 32'h500, 1'b0, 32'h0, 1'b0);
    look("fl904", 32'h904, 1'b0, 32'h0, 1'b0);
    look("flD00", 32'hD00, 1'b0, 32'h0, 1'b0);

    // Reset in the middle of a sweep aborts it.
    upd(32'h100, 32'h2000, 1'b1);
    look("retrain", 32'h100, 1'b1, 32'h2000, 1'b1);
    pulse_flush();
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst.busy", {31'b0, bus.flush_busy}, 32'h0);
    look("rst100", 32'h100, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pulse_flush();
    n = 0;
    while (bus.flush_busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("resweep.len", n, 128);
    chk("resweep.busy", {31'b0, bus.flush_busy}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/btb_assoc.md
# btb_assoc

Set-associative, parametrised branch target buffer with per-entry 2-bit-style direction hysteresis, tree pseudo-LRU replacement and a sequential flush engine. It sits beside the fetch stage. IF queries it combinationally with the fetch PC for a predicted target and direction. EX trains it with every resolved control-flow instruction.

## Interface
- ENTRIES, 256: total entries; ENTRIES/WAYS must be a power of two ≥ 2.
- WAYS, 2: associativity, one of 1, 2, 4, 8.
- CNT_W, 2: direction counter width, ≥ 1.
- Derived:
  - SETS = ENTRIES/WAYS
  - IDX_W = log2(SETS)
  - TAG_W = 32 − IDX_W − 2
  - index = pc[IDX_W+1:2]
  - tag = pc[31:IDX_W+2]

Ports:
- clk  in  1  clock, single domain, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- pc_if  in  32  fetch PC.
- hit_if  out  1  valid tag match in pc_if's set.
- target_if  out  32  matched way's target; 0 when hit_if=0.
- taken_if  out  1  MSB of matched way's counter; 0 when hit_if=0.
- update_en  in  1  resolved branch/jal/jalr in EX this cycle.
- pc_ex  in  32  PC of resolved instruction.
- target_ex  in  32  actual target.
- taken_ex  in  1  actual direction (1 for jal/jalr).
- flush_req  in  1  single-cycle pulse: invalidate whole BTB.
- flush_busy  out  1  flush sweep in progress.

## Operation
- Storage per way per set:
  - valid bit
  - TAG_W tag
  - 32-bit target
  - CNT_W counter
- Per set: WAYS−1 PLRU bits; none when WAYS=1.
- Lookup (IF, combinational):
  - Compare tag against all valid ways of the set.
  - At most one way can match, because allocation only happens on miss.
  - Outputs come from the matching way.
- Update (EX, registered), when update_en=1 and not flushing:
  - Tag hit in way w:
    - target ← target_ex.
    - Counter saturating +1 if taken_ex, else −1.
    - PLRU points away from w.
  - Miss with taken_ex=1, allocation:
    - Victim is the lowest-numbered invalid way; if all ways are valid, the PLRU victim.
    - Write valid=1, tag, target_ex.
    - Counter = 1<<(CNT_W−1) (weakly taken).
    - PLRU points away from the victim.
  - Miss with taken_ex=0: no state change.
- IF lookups do not modify PLRU.
- Flush FSM, states IDLE and SWEEP:
  - IDLE→SWEEP on flush_req; set counter s=0.
  - In SWEEP, each cycle clear valid and PLRU of set s, then s+1.
  - Leave SWEEP to IDLE after set SETS−1 is cleared.
  - flush_req during SWEEP is ignored.
- While flush_busy=1:
  - hit_if, target_if and taken_if are forced to 0.
  - update_en is ignored; the update is dropped.
- flush_req and update_en in the same IDLE cycle: the flush wins and the update is dropped.

## Timing
- Lookup latency 0: outputs depend combinationally on pc_if and current state.
- An update written at edge N is visible to lookups from cycle N+1.
- Same-cycle update and lookup to the same set: the lookup sees pre-update contents.
- flush_busy rises the cycle after flush_req and stays high exactly SETS cycles.
- A lookup in the first cycle after flush_busy falls misses everywhere.
- Reset, asynchronous:
  - All valid and PLRU bits cleared; FSM to IDLE; flush_busy=0.
  - As a result hit_if=0, target_if=0, taken_if=0.
  - Reset mid-sweep aborts the sweep.
- Targets, tags and counters are not reset; they are don't-care while invalid.

## Test plan
Defaults ENTRIES=256, WAYS=2, CNT_W=2 (index pc[8:2]).
- Reset then lookups:
  - pc_if=0x100 -> hit_if=0, target_if=0, taken_if=0.
  - After update_en with pc_ex=0x100, target_ex=0x2000, taken_ex=1, the next cycle pc_if=0x100 -> hit_if=1, target_if=0x2000, taken_if=1 (counter 2).
- Associativity and PLRU, all PCs in set 64:
  - Train taken 0x100→0xA00, then 0x300→0xB00: both hit.
  - Retrain 0x100 (now MRU), then train 0x500→0xC00 -> 0x300 evicted (miss), 0x100 and 0x500 hit.
- Hysteresis on 0x100 (counter 2):
  - Two not-taken updates -> counter 0, hit_if=1, taken_if=0, target unchanged.
  - Three taken updates -> taken_if=1, counter saturates at 3.
- Not-taken miss: update pc_ex=0x700, taken_ex=0 -> pc_if=0x700 still misses; resident ways of set 64 unchanged.
- Flush:
  - After training, pulse flush_req -> flush_busy high exactly 128 cycles, hit_if=0 throughout.
  - An update_en issued during the sweep is not retained.
  - All trained PCs miss afterwards.
- Reset mid-sweep: assert rst at sweep cycle 10 -> flush_busy=0 immediately, all lookups miss, a new flush_req restarts a full 128-cycle sweep.
